i2c_target_regs: RTL and testbench

- I2C target (slave) responder: the far end of the SoC's I2C master (i2c_scl / i2c_sda_in / i2c_sda_out / i2c_sda_oen).
- Exposes a small byte register bank over I2C, sampling SCL/SDA synchronously on the system clock.
- Used as on-board loopback/bring-up peer for the master and as a fabric-side control/status port.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_cond.sv | 76 +++++++
 rtl/i2c_target_regs.sv | 185 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes, byte framing constants and the
// majority vote used by the optional line glitch filter.
package i2c_pkg;

    localparam int I2C_BITS_PER_BYTE = 8;
    localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

    typedef logic [2:0] i2c_state_t;

    localparam i2c_state_t IDLE     = 3'd0;
    localparam i2c_state_t ADDR     = 3'd1;
    localparam i2c_state_t ADDR_ACK = 3'd2;
    localparam i2c_state_t WR_BYTE  = 3'd3;
    localparam i2c_state_t WR_ACK   = 3'd4;
    localparam i2c_state_t RD_BYTE  = 3'd5;
    localparam i2c_state_t RD_ACK   = 3'd6;
    localparam i2c_state_t IGNORE   = 3'd7;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchronisers, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN) and SCL edge / START / STOP detection.
module i2c_line_cond
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic scl_clean;
    logic sda_clean;
    logic scl_prev;
    logic sda_prev;

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist  <= '1;
            sda_hist  <= '1;
            scl_clean <= 1'b1;
            sda_clean <= 1'b1;
        end else begin
            scl_hist  <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist  <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_clean <= majority3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_clean <= majority3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end
`else
    assign scl_clean = scl_sync[SYNC_STAGES-1];
    assign sda_clean = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_clean;
            sda_prev <= sda_clean;
        end
    end

    // SCL must be high on both samples so an SDA move coincident with SCL falling is not a condition.
    assign sda      = sda_clean;
    assign scl_rise = scl_clean & ~scl_prev;
    assign scl_fall = ~scl_clean & scl_prev;
    assign start    = scl_clean & scl_prev & sda_prev & ~sda_clean;
    assign stop     = scl_clean & scl_prev & ~sda_prev & sda_clean;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register bank; optional line glitch
// filtering is enabled with I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PW          = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_out,
    output logic          sda_oen,
    input  logic [PW-1:0] reg_rd_addr,
    output logic [7:0]    reg_rd_data,
    output logic          wr_valid,
    output logic [PW-1:0] wr_reg,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [3:0] BYTE_BITS = 4'(I2C_BITS_PER_BYTE);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_state_t    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          rw;
    logic          first_byte;
    logic          rd_acked;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NUM_REGS];
    logic          addr_match;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    assign sda_out     = 1'b0;
    assign reg_rd_data = regs[reg_rd_addr];
    assign addr_match  = (shifter[7:1] == I2C_ADDR) && (shifter[7:1] != I2C_GENERAL_CALL);

    // SDA is sampled on SCL rise; every sda_oen update is made on an SCL fall so it lands while SCL is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shifter    <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            rd_acked   <= 1'b0;
            ptr        <= '0;
            sda_oen    <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_reg     <= '0;
            wr_data    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_valid <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oen <= 1'b0;
            end else if (stop) begin
                state   <= IDLE;
                sda_oen <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == BYTE_BITS) begin
                            bit_cnt <= '0;
                            if (addr_match) begin
                                state   <= ADDR_ACK;
                                sda_oen <= 1'b1;
                                busy    <= 1'b1;
                                rw      <= shifter[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shifter <= regs[ptr];
                                sda_oen <= ~regs[ptr][7];
                                state   <= RD_BYTE;
                            end else begin
                                sda_oen    <= 1'b0;
                                first_byte <= 1'b1;
                                state      <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == BYTE_BITS) begin
                            bit_cnt <= '0;
                            sda_oen <= 1'b1;
                            state   <= WR_ACK;
                            if (first_byte) begin
                                ptr        <= shifter[PW-1:0];
                                first_byte <= 1'b0;
                            end else begin
                                regs[ptr] <= shifter;
                                wr_valid  <= 1'b1;
                                wr_reg    <= ptr;
                                wr_data   <= shifter;
                                ptr       <= ptr + PW'(1);
                            end
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oen <= 1'b0;
                            state   <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        // The MSB went out at load time, so falls 0..6 present bits 6..0 and fall 7 releases the line.
                        if (scl_fall) begin
                            if (bit_cnt == BYTE_BITS - 4'd1) begin
                                bit_cnt  <= '0;
                                sda_oen  <= 1'b0;
                                ptr      <= ptr + PW'(1);
                                rd_acked <= 1'b0;
                                state    <= RD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shifter <= {shifter[6:0], 1'b0};
                                sda_oen <= ~shifter[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda) begin
                                shifter  <= regs[ptr];
                                rd_acked <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && rd_acked) begin
                            rd_acked <= 1'b0;
                            sda_oen  <= ~shifter[7];
                            state    <= RD_BYTE;
                        end
                    end
                    IDLE, IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed and randomized bench for i2c_target_regs; the glitch step's
// expectation depends on I2C_TARGET_GLITCH_FILTER_EN.
module tb_i2c_target_regs;

    localparam logic [6:0] TGT_ADDR = 7'h42;
    localparam int NUM_REGS = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          scl_m;
    logic          sda_m;
    logic          sda_bus;
    logic          sda_out;
    logic          sda_oen;
    logic [PW-1:0] reg_rd_addr;
    logic [7:0]    reg_rd_data;
    logic          wr_valid;
    logic [PW-1:0] wr_reg;
    logic [7:0]    wr_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]      model_regs [NUM_REGS];
    int              model_ptr;
    logic [PW+7:0]   wr_q  [$];
    logic [PW+7:0]   exp_q [$];
    logic [7:0]      tx_data [$];
    bit              oen_seen;
    bit              busy_seen;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_m & ~sda_oen;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .I2C_ADDR   (TGT_ADDR),
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_out    (sda_out),
        .sda_oen    (sda_oen),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .wr_valid   (wr_valid),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_q.push_back({wr_reg, wr_data});
        if (sda_oen) oen_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic scl_v, input logic sda_v, input int n);
        scl_m = scl_v;
        sda_m = sda_v;
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            applyStimulus(1'b0, 1'b1, 8);
            applyStimulus(1'b1, 1'b1, 10);
        end
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 4);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 10);
    endtask

    // glitch_bit selects a bit (which must be a 1) that gets a one-clock low pulse mid SCL-high.
    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, b[i], 6);
            if (i == glitch_bit) begin
                applyStimulus(1'b1, b[i], 5);
                applyStimulus(1'b1, 1'b0, 1);
                applyStimulus(1'b1, b[i], 4);
            end else begin
                applyStimulus(1'b1, b[i], 10);
            end
            applyStimulus(1'b0, b[i], 2);
        end
        applyStimulus(1'b0, 1'b1, 6);
        applyStimulus(1'b1, 1'b1, 5);
        ack = sda_bus;
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b0, 1'b1, 2);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, 8);
            applyStimulus(1'b1, 1'b1, 5);
            b[i] = sda_bus;
            applyStimulus(1'b1, 1'b1, 5);
        end
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, ack_bit, 6);
        applyStimulus(1'b1, ack_bit, 10);
        applyStimulus(1'b0, ack_bit, 2);
    endtask

    task automatic check_wr_events();
        checkOutput("wr_count", wr_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) checkOutput("wr_event", wr_q[i], exp_q[i]);
        end
    endtask

    task automatic check_regs();
        for (int a = 0; a < NUM_REGS; a++) begin
            reg_rd_addr = PW'(a);
            #1;
            checkOutput("reg_rd_data", reg_rd_data, model_regs[a]);
        end
    endtask

    task automatic model_store(input logic [7:0] d);
        exp_q.push_back({PW'(model_ptr), d});
        model_regs[model_ptr] = d;
        model_ptr = (model_ptr + 1) % NUM_REGS;
    endtask

    // Write transaction: pointer byte then every byte queued in tx_data.
    task automatic do_write(input logic [7:0] ptrb);
        logic ack;
        wr_q.delete();
        exp_q.delete();
        i2c_start();
        write_byte({TGT_ADDR, 1'b0}, -1, ack);
        checkOutput("wr_addr_ack", ack, 1'b0);
        checkOutput("busy_on", busy, 1'b1);
        write_byte(ptrb, -1, ack);
        checkOutput("ptr_ack", ack, 1'b0);
        model_ptr = ptrb % NUM_REGS;
        foreach (tx_data[i]) begin
            write_byte(tx_data[i], -1, ack);
            checkOutput("data_ack", ack, 1'b0);
            model_store(tx_data[i]);
        end
        i2c_stop();
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("busy_off", busy, 1'b0);
        check_wr_events();
    endtask

    // Read of n bytes, either after setting the pointer with a repeated START or from the current pointer.
    task automatic do_read(input bit set_ptr, input logic [7:0] ptrb, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            write_byte({TGT_ADDR, 1'b0}, -1, ack);
            checkOutput("rd_setup_ack", ack, 1'b0);
            write_byte(ptrb, -1, ack);
            checkOutput("rd_ptr_ack", ack, 1'b0);
            model_ptr = ptrb % NUM_REGS;
            i2c_start();
        end
        write_byte({TGT_ADDR, 1'b1}, -1, ack);
        checkOutput("rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            checkOutput("rd_byte", b, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % NUM_REGS;
        end
        i2c_stop();
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("busy_off_rd", busy, 1'b0);
    endtask

    initial begin
        logic ack;
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        reg_rd_addr = '0;
        model_ptr = 0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        repeat (4) @(negedge clk);
        checkOutput("rst_sda_oen", sda_oen, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_wr_valid", wr_valid, 1'b0);
        checkOutput("rst_wr_reg", wr_reg, '0);
        checkOutput("rst_wr_data", wr_data, 8'h00);
        checkOutput("rst_sda_out", sda_out, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 10);
        check_regs();

        // Basic write: pointer 1, then A5, 5A.
        tx_data = '{8'hA5, 8'h5A};
        do_write(8'h01);
        reg_rd_addr = 2'd2;
        #1;
        checkOutput("reg2_after_write", reg_rd_data, 8'h5A);

        // Read across the wrap point, then again with known contents.
        do_read(1'b1, 8'h03, 2);
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(8'h00);
        do_read(1'b1, 8'h03, 2);

        // Address mismatch must never drive SDA or go busy.
        wr_q.delete();
        oen_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, -1, ack);
        checkOutput("mismatch_addr_nack", ack, 1'b1);
        write_byte(8'hFF, -1, ack);
        checkOutput("mismatch_data_nack", ack, 1'b1);
        i2c_stop();
        applyStimulus(1'b1, 1'b1, 4);
        checkOutput("mismatch_oen_seen", oen_seen, 1'b0);
        checkOutput("mismatch_busy_seen", busy_seen, 1'b0);
        checkOutput("mismatch_wr_count", wr_q.size(), 0);

        // Upper pointer bits are dropped.
        tx_data = '{8'h77};
        do_write(8'hF6);
        reg_rd_addr = 2'd2;
        #1;
        checkOutput("mask_reg2", reg_rd_data, 8'h77);

        // Reset while the target is driving a 0 data bit.
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(8'h00);
        i2c_start();
        write_byte({TGT_ADDR, 1'b1}, -1, ack);
        checkOutput("rst_rd_addr_ack", ack, 1'b0);
        applyStimulus(1'b0, 1'b1, 6);
        checkOutput("rst_rd_driving", sda_oen, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_oen", sda_oen, 1'b0);
        checkOutput("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        i2c_stop();
        tx_data = '{8'h3C};
        do_write(8'h02);
        check_regs();

        // One-clock SDA low pulse while SCL is high, inside a data byte.
        wr_q.delete();
        exp_q.delete();
        i2c_start();
        write_byte({TGT_ADDR, 1'b0}, -1, ack);
        checkOutput("gl_addr_ack", ack, 1'b0);
        write_byte(8'h01, -1, ack);
        checkOutput("gl_ptr_ack", ack, 1'b0);
        model_ptr = 1;
        write_byte(8'hFF, 4, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        checkOutput("gl_data_ack", ack, 1'b0);
        checkOutput("gl_busy", busy, 1'b1);
        model_store(8'hFF);
`else
        checkOutput("gl_data_ack", ack, 1'b1);
        checkOutput("gl_busy", busy, 1'b0);
`endif
        i2c_stop();
        applyStimulus(1'b1, 1'b1, 4);
        check_wr_events();
        check_regs();

        // Randomized mix of writes, pointer-set reads and current-address reads.
        for (int k = 0; k < 10; k++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            if (kind == 0) begin
                tx_data.delete();
                for (int j = 0; j < n; j++) tx_data.push_back(8'($urandom));
                do_write(8'($urandom));
            end else begin
                do_read(kind == 1, 8'($urandom), n);
            end
        end
        check_regs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
